// File: rtl/gpu_op_dispatcher.sv
// gpu_op_dispatcher: pops one queued op at a time, runs its memory beats and issues it to the execution unit.
module gpu_op_dispatcher #(
    parameter int INSTR_WIDTH    = 80,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_q_valid,
    input  logic [INSTR_WIDTH-1:0] i_q_instruction,
    input  logic [ADDR_WIDTH-1:0]  i_q_src_addr,
    input  logic [ADDR_WIDTH-1:0]  i_q_dst_addr,
    output logic                   o_q_dequeue_req,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [DATA_WIDTH-1:0]  o_mem_wdata,
    input  logic                   i_mem_ack,
    input  logic [DATA_WIDTH-1:0]  i_mem_rdata,
    output logic                   o_exec_valid,
    output logic [7:0]             o_exec_opcode,
    output logic [3:0]             o_exec_dest,
    output logic                   o_exec_vector,
    output logic [DATA_WIDTH-1:0]  o_exec_operand,
    input  logic                   i_exec_ready,
    output logic                   o_busy,
    output logic [15:0]            o_ops_done,
    output logic                   o_timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, ISSUE} state_t;

    state_t                r_state, w_next;
    logic                  r_rd, r_wr, r_multi, r_beat;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [TW-1:0]         r_tmo;
    logic                  w_rd, w_wr, w_ack, w_tmo, w_last, w_fire, w_done;

    assign w_rd            = i_q_instruction[2];
    assign w_wr            = i_q_instruction[1];
    assign o_q_dequeue_req = (r_state == IDLE) && i_enable && i_q_valid;
    assign w_ack           = o_mem_req && i_mem_ack;
    assign w_tmo           = o_mem_req && !i_mem_ack && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    // a copy writes a single beat; write-only ops may carry a second beat
    assign w_last          = r_rd || !r_multi || r_beat;
    assign w_fire          = o_exec_valid && i_exec_ready;
    assign w_done          = (r_state == MEM_WR && w_ack && w_last) || (r_state == ISSUE && w_fire);
    assign o_busy          = r_state != IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !o_q_dequeue_req ? IDLE : w_rd ? MEM_RD : w_wr ? MEM_WR : ISSUE;
            MEM_RD:  w_next = w_tmo ? IDLE : !w_ack ? MEM_RD : r_wr ? MEM_WR : ISSUE;
            MEM_WR:  w_next = (w_tmo || (w_ack && w_last)) ? IDLE : MEM_WR;
            ISSUE:   w_next = w_fire ? IDLE : ISSUE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd           <= 1'b0;
            r_wr           <= 1'b0;
            r_multi        <= 1'b0;
            r_beat         <= 1'b0;
            r_dst          <= '0;
            r_hi           <= '0;
            r_tmo          <= '0;
            o_mem_req      <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
            o_exec_valid   <= 1'b0;
            o_exec_opcode  <= '0;
            o_exec_dest    <= '0;
            o_exec_vector  <= 1'b0;
            o_exec_operand <= '0;
            o_ops_done     <= '0;
            o_timeout_err  <= 1'b0;
        end else begin
            o_ops_done <= o_ops_done + 16'(w_done);
            if (o_q_dequeue_req) begin
                r_rd           <= w_rd;
                r_wr           <= w_wr;
                r_multi        <= i_q_instruction[3];
                r_beat         <= 1'b0;
                r_dst          <= i_q_dst_addr;
                r_hi           <= i_q_instruction[16+DATA_WIDTH +: DATA_WIDTH];
                o_mem_req      <= w_rd || w_wr;
                o_mem_we       <= w_wr && !w_rd;
                o_mem_addr     <= w_rd ? i_q_src_addr : i_q_dst_addr;
                o_mem_wdata    <= i_q_instruction[16 +: DATA_WIDTH];
                o_exec_valid   <= !w_rd && !w_wr;
                o_exec_opcode  <= i_q_instruction[11:4];
                o_exec_dest    <= i_q_instruction[15:12];
                o_exec_vector  <= i_q_instruction[0];
                o_exec_operand <= i_q_instruction[16 +: DATA_WIDTH];
            end
            if (w_fire)
                o_exec_valid <= 1'b0;
            if (w_tmo) begin
                o_mem_req     <= 1'b0;
                r_tmo         <= '0;
                o_timeout_err <= 1'b1;
            end else if (w_ack) begin
                o_mem_req <= 1'b0;
                r_tmo     <= '0;
                if (r_state == MEM_RD) begin
                    o_mem_we       <= 1'b1;
                    o_mem_addr     <= r_dst;
                    o_mem_wdata    <= i_mem_rdata;
                    o_exec_operand <= i_mem_rdata;
                    o_exec_valid   <= !r_wr;
                end else begin
                    r_beat      <= 1'b1;
                    o_mem_addr  <= r_dst + ADDR_WIDTH'(4);
                    o_mem_wdata <= r_hi;
                end
            end else if (o_mem_req) begin
                r_tmo <= r_tmo + TW'(1);
            end else if (r_state == MEM_WR) begin
                // one idle cycle separates beats before req is raised again
                o_mem_req <= 1'b1;
            end
        end
    end
endmodule
